uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_if.sv | 26 ++
 rtl/baud_tick_gen.sv | 37 +++
 rtl/uart_tx.sv | 105 ++++++++++
 tb/tb_uart_tx.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, frame defaults and counter sizing helper
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uart_state_e;

    localparam int DBITS_DEF    = 8;
    localparam int OS_TICKS_DEF = 16;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - transmit request/status bundle between a client and uart_tx
interface uart_tx_if #(
    parameter int DBITS = 8
) ();
    logic             tx_start;
    logic [DBITS-1:0] tx_din;
    logic             tx;
    logic             tx_busy;
    logic             tx_done;

    modport master (
        output tx_start,
        output tx_din,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_din,
        output tx,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - clk divider producing one oversampling tick every DVSR enabled cycles
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DVSR = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int            DW   = cnt_w(DVSR);
    localparam logic [DW-1:0] LAST = DW'(DVSR - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (clr) begin
            div_d = '0;
        end else if (en) begin
            div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = en && !clr && (div_q == LAST);
endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1-style serial transmitter: start bit, DBITS data LSB first, stop bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBITS    = DBITS_DEF,
    parameter int OS_TICKS = OS_TICKS_DEF,
    parameter int DVSR     = 16
) (
    input logic     clk,
    input logic     rst,
    uart_tx_if.slave bus
);
    localparam int            TW        = cnt_w(OS_TICKS);
    localparam int            BW        = cnt_w(DBITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OS_TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBITS - 1);

    uart_state_e      state_q;
    logic [DBITS-1:0] sh_q;
    logic [DBITS-1:0] sh_d;
    logic [TW-1:0]    tick_cnt_q;
    logic [TW-1:0]    tick_cnt_d;
    logic [BW-1:0]    bit_cnt_q;
    logic             tx_q;
    logic             busy_q;
    logic             tick;
    logic             last_tick;
    logic             accept;
    logic             div_en;

    assign accept     = (state_q == ST_IDLE) && bus.tx_start;
    assign div_en     = (state_q != ST_IDLE);
    assign tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
    assign last_tick  = tick && (tick_cnt_q == TICK_LAST);
    assign sh_d       = sh_q >> 1;

    baud_tick_gen #(.DVSR(DVSR)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .clr  (accept),
        .tick (tick)
    );

    // tx is loaded with the value of the bit that begins on the next cycle,
    // so the line changes exactly at each bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            if (div_en && tick) begin
                tick_cnt_q <= tick_cnt_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.tx_start) begin
                        state_q    <= ST_START;
                        sh_q       <= bus.tx_din;
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (last_tick) begin
                        state_q <= ST_DATA;
                        tx_q    <= sh_q[0];
                    end
                end
                ST_DATA: begin
                    if (last_tick) begin
                        sh_q <= sh_d;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            tx_q      <= sh_d[0];
                        end
                    end
                end
                ST_STOP: begin
                    if (last_tick) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        tx_q    <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Done marks the final cycle of the stop bit, so a request in that cycle
    // still sees a busy FSM and the next frame starts after one idle cycle.
    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = (state_q == ST_STOP) && last_tick;
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx (DVSR=2, OS_TICKS=16, DBITS=8)
module tb_uart_tx;
    localparam int BIT_CYC   = 32;
    localparam int FRAME_CYC = 320;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    uart_tx_if #(.DBITS(8)) bus ();

    uart_tx #(
        .DBITS    (8),
        .OS_TICKS (16),
        .DVSR     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        else if (b <= 8) return d[b-1];
        else return 1'b1;
    endfunction

    // Entered in the first start-bit cycle; returns in the first idle cycle after the frame.
    task automatic frame_chk(input logic [7:0] d, input string tag,
                             input int pulse_at, input logic [7:0] pulse_d);
        int match;
        int busy_n;
        int done_n;
        int done_at;
        match   = 0;
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        for (int i = 0; i < FRAME_CYC; i++) begin
            if (bus.tx === exp_bit(d, i / BIT_CYC)) match++;
            if (bus.tx_busy === 1'b1) busy_n++;
            if (bus.tx_done === 1'b1) begin
                done_n++;
                done_at = i;
            end
            if (i % BIT_CYC == BIT_CYC - 1) begin
                chk($sformatf("%s_bit%0d", tag, i / BIT_CYC), match, BIT_CYC);
                match = 0;
            end
            if (i == pulse_at) begin
                bus.tx_start = 1'b1;
                bus.tx_din   = pulse_d;
            end
            if (pulse_at >= 0 && i == pulse_at + 1) bus.tx_start = 1'b0;
            step();
        end
        if (pulse_at == FRAME_CYC - 1) bus.tx_start = 1'b0;
        chk({tag, "_busy_cycles"}, busy_n, FRAME_CYC);
        chk({tag, "_done_count"}, done_n, 1);
        chk({tag, "_done_cycle"}, done_at, FRAME_CYC - 1);
        chk({tag, "_end_tx"}, bus.tx, 1);
        chk({tag, "_end_busy"}, bus.tx_busy, 0);
        chk({tag, "_end_done"}, bus.tx_done, 0);
    endtask

    initial begin
        int idle_n;
        int done_n;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_din   = 8'h00;
        repeat (3) step();
        chk("rst_tx", bus.tx, 1);
        chk("rst_busy", bus.tx_busy, 0);
        chk("rst_done", bus.tx_done, 0);
        rst = 1'b0;
        step();
        chk("idle_tx", bus.tx, 1);

        bus.tx_din   = 8'hA5;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
        frame_chk(8'hA5, "a5", -1, 8'h00);
        step();
        chk("a5_after_tx", bus.tx, 1);
        chk("a5_after_busy", bus.tx_busy, 0);

        bus.tx_din   = 8'h00;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
        frame_chk(8'h00, "b2b_00", -1, 8'h00);
        bus.tx_din   = 8'hFF;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
        frame_chk(8'hFF, "b2b_ff", FRAME_CYC - 1, 8'h3C);
        step();
        chk("done_cycle_req_tx", bus.tx, 1);
        chk("done_cycle_req_busy", bus.tx_busy, 0);

        bus.tx_din   = 8'h81;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
        frame_chk(8'h81, "busy_req", 100, 8'h3C);
        idle_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.tx === 1'b1 && bus.tx_busy === 1'b0) idle_n++;
            step();
        end
        chk("busy_req_no_second_frame", idle_n, 40);

        bus.tx_din   = 8'h55;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
        repeat (100) step();
        chk("pre_rst_busy", bus.tx_busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", bus.tx, 1);
        chk("mid_rst_busy", bus.tx_busy, 0);
        chk("mid_rst_done", bus.tx_done, 0);
        step();
        step();
        rst    = 1'b0;
        done_n = 0;
        idle_n = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.tx_done === 1'b1) done_n++;
            if (bus.tx === 1'b1 && bus.tx_busy === 1'b0) idle_n++;
            step();
        end
        chk("post_rst_no_done", done_n, 0);
        chk("post_rst_idle", idle_n, 300);
        bus.tx_din   = 8'h0F;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
        frame_chk(8'h0F, "post_rst_0f", -1, 8'h00);

        bus.tx_din   = 8'h96;
        bus.tx_start = 1'b1;
        step();
        frame_chk(8'h96, "hold0", -1, 8'h00);
        step();
        frame_chk(8'h96, "hold1", -1, 8'h00);
        step();
        frame_chk(8'h96, "hold2", -1, 8'h00);
        bus.tx_start = 1'b0;
        step();
        chk("hold_release_tx", bus.tx, 1);
        chk("hold_release_busy", bus.tx_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
